// File: rtl/uart_cmd_assembler.sv
// Assembles fixed-length commands from a UART byte stream, MSB byte first, with an inter-byte timeout.
// Optional trailing checksum byte when CHECKSUM_EN is defined.
module uart_cmd_assembler #(
    parameter int BYTES   = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_rdy,
    input  logic [7:0]           rx_data,
    output logic                 clr_rx_rdy,
    input  logic                 clr_cmd_rdy,
    output logic [8*BYTES-1:0]   cmd,
    output logic                 cmd_rdy,
    output logic                 timeout,
    output logic                 cmd_err
);

    localparam int          W        = 8 * BYTES;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_CNT = 3'(BYTES - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t          state_q;
    logic [W-1:0]    cmd_q;
    logic [W-1:0]    cmd_d;
    logic [2:0]      byte_cnt_q;
    logic [15:0]     timer_q;
    logic [15:0]     timer_d;
    logic            cmd_rdy_q;
    logic            timeout_q;
    logic            expire;
    logic            last_payload;

    // Every state accepts a waiting byte; the handshake is gated by reset so it reads 0 while held.
    assign clr_rx_rdy   = rx_rdy & rst_n;
    assign cmd_d        = {cmd_q[W-9:0], rx_data};
    assign timer_d      = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    assign expire       = (timer_q == TMO_LAST);
    assign last_payload = (byte_cnt_q == LAST_CNT);

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic       cmd_err_q;

    assign sum_d   = sum_q + rx_data;
    assign cmd_err = cmd_err_q;
`else
    assign cmd_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            byte_cnt_q <= 3'd0;
            timer_q    <= 16'd0;
            cmd_rdy_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q      <= 8'd0;
            cmd_err_q  <= 1'b0;
`endif
        end else begin
            timeout_q <= 1'b0;
`ifdef CHECKSUM_EN
            cmd_err_q <= 1'b0;
`endif
            // Placed before the FSM so a completing command in the same cycle wins.
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rx_rdy) begin
                        cmd_rdy_q  <= 1'b0;
                        cmd_q      <= cmd_d;
                        byte_cnt_q <= 3'd1;
                        timer_q    <= 16'd0;
`ifdef CHECKSUM_EN
                        sum_q      <= rx_data;
`endif
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_rdy) begin
                        cmd_q      <= cmd_d;
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        timer_q    <= 16'd0;
`ifdef CHECKSUM_EN
                        sum_q      <= sum_d;
                        if (last_payload) begin
                            state_q <= CHECK;
                        end
`else
                        if (last_payload) begin
                            state_q   <= IDLE;
                            cmd_rdy_q <= 1'b1;
                        end
`endif
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        timer_q   <= 16'd0;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`ifdef CHECKSUM_EN
                CHECK: begin
                    if (rx_rdy) begin
                        timer_q <= 16'd0;
                        state_q <= IDLE;
                        if (sum_d == 8'hFF) begin
                            cmd_rdy_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        timer_q   <= 16'd0;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler: a long-timeout and a short-timeout (TIMEOUT=20) instance share stimulus.
module tb_uart_cmd_assembler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;

    logic        clr_rx_rdy_l, cmd_rdy_l, timeout_l, cmd_err_l;
    logic [23:0] cmd_l;
    logic        clr_rx_rdy_s, cmd_rdy_s, timeout_s, cmd_err_s;
    logic [23:0] cmd_s;

    int          vectors = 0;
    int          miscompares = 0;
    int          clr_cnt_l = 0;
    logic [7:0]  tb_sum = 8'h00;

    uart_cmd_assembler #(.BYTES(3), .TIMEOUT(50000)) dut_l (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy_l), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd_l),
        .cmd_rdy(cmd_rdy_l), .timeout(timeout_l), .cmd_err(cmd_err_l)
    );

    uart_cmd_assembler #(.BYTES(3), .TIMEOUT(20)) dut_s (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy_s), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd_s),
        .cmd_rdy(cmd_rdy_s), .timeout(timeout_s), .cmd_err(cmd_err_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_rx_rdy_l) clr_cnt_l <= clr_cnt_l + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one byte for a single cycle; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = with_clr;
        tb_sum      = tb_sum + b;
        #1 chk("clr_rx_rdy", 32'(clr_rx_rdy_s), 32'h1);
        @(negedge clk);
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic finish_frame(input logic with_clr);
`ifdef CHECKSUM_EN
        send_byte(8'hFF - tb_sum, with_clr);
`else
        if (with_clr) begin
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
        end
`endif
        tb_sum = 8'h00;
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n       = 1'b0;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        idle(2);
        rst_n  = 1'b1;
        tb_sum = 8'h00;
    endtask

    initial begin
        // Reset state
        idle(1);
        chk("rst_cmd", 32'(cmd_s), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy_s), 32'h0);
        chk("rst_timeout", 32'(timeout_s), 32'h0);
        chk("rst_cmd_err", 32'(cmd_err_s), 32'h0);
        chk("rst_clr_rx", 32'(clr_rx_rdy_s), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Slow bytes, 100 cycles apart, on the long-timeout instance
        send_byte(8'hA5, 1'b0);
        idle(98);
        send_byte(8'h12, 1'b0);
        chk("t1_rdy_early", 32'(cmd_rdy_l), 32'h0);
        idle(98);
        send_byte(8'h3C, 1'b0);
        chk("t1_clr_pulses", 32'(clr_cnt_l), 32'd3);
        finish_frame(1'b0);
        chk("t1_cmd", 32'(cmd_l), 32'hA5123C);
        chk("t1_cmd_rdy", 32'(cmd_rdy_l), 32'h1);
        chk("t1_timeout", 32'(timeout_l), 32'h0);
        idle(3);
        chk("t1_rdy_hold", 32'(cmd_rdy_l), 32'h1);
        chk("t1_cmd_hold", 32'(cmd_l), 32'hA5123C);
        pulse_clr();
        chk("t1_rdy_cleared", 32'(cmd_rdy_l), 32'h0);

        // Truncated frame times out 20 cycles after the last accepted byte
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        idle(19);
        chk("t2_tmo_early", 32'(timeout_s), 32'h0);
        idle(1);
        chk("t2_tmo_pulse", 32'(timeout_s), 32'h1);
        chk("t2_rdy_after_tmo", 32'(cmd_rdy_s), 32'h0);
        idle(1);
        chk("t2_tmo_end", 32'(timeout_s), 32'h0);
        tb_sum = 8'h00;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        finish_frame(1'b0);
        chk("t2_cmd", 32'(cmd_s), 32'h112233);
        chk("t2_cmd_rdy", 32'(cmd_rdy_s), 32'h1);

        // New first byte invalidates a pending command
        idle(2);
        send_byte(8'hFF, 1'b0);
        chk("t3_rdy_dropped", 32'(cmd_rdy_s), 32'h0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        finish_frame(1'b0);
        chk("t3_cmd", 32'(cmd_s), 32'hFF0102);
        chk("t3_cmd_rdy", 32'(cmd_rdy_s), 32'h1);

        // Reset mid-command
        pulse_clr();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_cmd", 32'(cmd_s), 32'h0);
        chk("t4_rst_rdy", 32'(cmd_rdy_s), 32'h0);
        chk("t4_rst_tmo", 32'(timeout_s), 32'h0);
        idle(2);
        rst_n  = 1'b1;
        tb_sum = 8'h00;
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'h0C, 1'b0);
        finish_frame(1'b0);
        chk("t4_cmd", 32'(cmd_s), 32'h0A0B0C);
        chk("t4_cmd_rdy", 32'(cmd_rdy_s), 32'h1);

        // Byte lands in the cycle the timer reaches TIMEOUT-1
        pulse_clr();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        idle(18);
        chk("t5_tmo_none_yet", 32'(timeout_s), 32'h0);
        send_byte(8'h03, 1'b0);
        chk("t5_tmo_suppressed", 32'(timeout_s), 32'h0);
        finish_frame(1'b0);
        chk("t5_cmd", 32'(cmd_s), 32'h010203);
        chk("t5_cmd_rdy", 32'(cmd_rdy_s), 32'h1);
        idle(2);
        chk("t5_tmo_after", 32'(timeout_s), 32'h0);

        // Completion and clr_cmd_rdy in the same cycle: set wins
        pulse_clr();
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
`ifdef CHECKSUM_EN
        send_byte(8'h23, 1'b0);
        finish_frame(1'b1);
`else
        send_byte(8'h23, 1'b1);
        finish_frame(1'b0);
`endif
        chk("t6_set_wins", 32'(cmd_rdy_s), 32'h1);
        chk("t6_cmd", 32'(cmd_s), 32'h212223);

`ifdef CHECKSUM_EN
        // Checksum pass then fail
        do_reset();
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h9F, 1'b0);
        chk("cs_pass_rdy", 32'(cmd_rdy_s), 32'h1);
        chk("cs_pass_err", 32'(cmd_err_s), 32'h0);
        chk("cs_pass_cmd", 32'(cmd_s), 32'h102030);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h9E, 1'b0);
        chk("cs_fail_rdy", 32'(cmd_rdy_s), 32'h0);
        chk("cs_fail_err", 32'(cmd_err_s), 32'h1);
        idle(1);
        chk("cs_err_end", 32'(cmd_err_s), 32'h0);
`else
        chk("no_cmd_err", 32'(cmd_err_s), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
